// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
//   MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM
//   register. Loads and stores are issued to a multi-cycle data memory over a
//   req/ack handshake. While an access is outstanding the stage stalls the
//   pipeline. The write-back result, destination and control go into the
//   MEM/WB outputs.
//
//   Ports
//     clk, rst                 rising-edge clock, async active-high reset
//     ex_valid                 EX/MEM holds a real instruction (0 = bubble)
//     alu_res, store_data      ALU result / memory address, store data
//     nxt_pc                   PC+1, link value for jal
//     mem_read, mem_write      load / store (store wins if both are set)
//     reg_write, jal, halt     write-back control, link select, halt marker
//     dst                      destination register
//     dmem_req/we/addr/wdata   request side of the data-memory handshake
//     dmem_ack, dmem_rdata     completion strobe and load data (same cycle)
//     stall                    combinational hold for EX/MEM and upstream
//     wb_valid, wb_reg_write,
//     wb_dst, wb_data, wb_halt MEM/WB register outputs
//     mem_err                  sticky access-timeout flag
//
//   TIMEOUT is the number of BUSY cycles without an ack that the stage
//   tolerates before it declares an error. The legal range is 1..255.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access outstanding; non-memory ops pass in one cycle
//   BUSY   | request on dmem, waiting for ack; address/data held stable
//   ERR    | ack never came; pipeline frozen until reset
//   HALTED | a valid halt reached MEM/WB; pipeline frozen until reset

module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] alu_res,
  input  logic [15:0] store_data,
  input  logic [15:0] nxt_pc,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        jal,
  input  logic        halt,
  input  logic [4:0]  dst,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dst,
  output logic [15:0] wb_data,
  output logic        wb_halt,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    ERR    = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic        memop;
  logic        halt_in;
  logic        stall_int;
  logic        capture;
  logic        latch_req;
  logic [15:0] wb_data_d;

  assign memop   = ex_valid & (mem_read | mem_write);
  assign halt_in = ex_valid & halt;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    capture   = 1'b0;
    latch_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_int = 1'b1;
          latch_req = 1'b1;
          cnt_d     = 8'd0;
          state_d   = BUSY;
        end else begin
          capture = 1'b1;
          if (halt_in) state_d = HALTED;
        end
      end
      BUSY: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (dmem_ack) begin
          capture = 1'b1;
          cnt_d   = 8'd0;
          state_d = halt_in ? HALTED : IDLE;
        end else begin
          stall_int = 1'b1;
          cnt_d     = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) state_d = ERR;
        end
      end
      ERR:     stall_int = 1'b1;
      HALTED:  stall_int = 1'b1;
      default: state_d   = IDLE;
    endcase
  end

  // Reset has to clear stall immediately even when a memop is presented,
  // so the combinational stall is also gated by the reset pin.
  assign stall = stall_int & ~rst;

  assign dmem_req = (state_q == BUSY);
  assign mem_err  = (state_q == ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= 16'd0;
      dmem_wdata <= 16'd0;
    end else if (latch_req) begin
      dmem_we    <= mem_write;
      dmem_addr  <= alu_res;
      dmem_wdata <= store_data;
    end
  end

  always_comb begin
    wb_data_d = alu_res;
    if (jal)                        wb_data_d = nxt_pc;
    else if (mem_read & ~mem_write) wb_data_d = dmem_rdata;
  end

  // Stalled edges load a bubble. In HALTED the last values are held so the
  // halt marker stays visible to WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dst       <= 5'd0;
      wb_data      <= 16'd0;
      wb_halt      <= 1'b0;
    end else if (capture) begin
      wb_valid     <= ex_valid;
      wb_reg_write <= ex_valid & reg_write & ~mem_write;
      wb_dst       <= dst;
      wb_data      <= wb_data_d;
      wb_halt      <= halt_in;
    end else if (state_q != HALTED) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_halt      <= 1'b0;
    end
  end

endmodule
